// File: rtl/qx1_exec_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : qx1_exec_ctrl_pkg
// Description : Shared definitions for the QX1 execute sequencer: opcode
//               map, ALU control encodings, FSM state encodings,
//               instruction field positions and decode helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package qx1_exec_ctrl_pkg;

  // Opcode map (instr[15:12])
  localparam logic [3:0] OP_LW       = 4'h0;
  localparam logic [3:0] OP_SW       = 4'h1;
  localparam logic [3:0] OP_RT_FIRST = 4'h2;
  localparam logic [3:0] OP_RT_LAST  = 4'h9;
  localparam logic [3:0] OP_BEQ      = 4'hA;
  localparam logic [3:0] OP_BNE      = 4'hB;
  localparam logic [3:0] OP_JMP      = 4'hC;

  // ALU control encodings
  localparam logic [1:0] ALU_OP_ADD  = 2'b10;
  localparam logic [1:0] ALU_OP_SUB  = 2'b01;
  localparam logic [1:0] ALU_OP_FUNC = 2'b00;

  // FSM state encodings
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_DECODE = 3'd1;
  localparam logic [2:0] ST_EXEC   = 3'd2;
  localparam logic [2:0] ST_MEM    = 3'd3;
  localparam logic [2:0] ST_WB     = 3'd4;

  // Instruction field bit positions
  localparam int OPC_HI = 15;
  localparam int OPC_LO = 12;
  localparam int RD_HI  = 11;
  localparam int RD_LO  = 9;
  localparam int RS1_HI = 8;
  localparam int RS1_LO = 6;
  localparam int RS2_HI = 5;
  localparam int RS2_LO = 3;

  // Coarse instruction class used to steer the sequencer
  typedef enum logic [2:0] {
    CLS_LOAD    = 3'd0,
    CLS_STORE   = 3'd1,
    CLS_ALU     = 3'd2,
    CLS_BEQ     = 3'd3,
    CLS_BNE     = 3'd4,
    CLS_JMP     = 3'd5,
    CLS_ILLEGAL = 3'd6
  } op_class_e;

  function automatic op_class_e classify(input logic [3:0] opc);
    op_class_e cls;
    if (opc == OP_LW)            cls = CLS_LOAD;
    else if (opc == OP_SW)       cls = CLS_STORE;
    else if (opc <= OP_RT_LAST)  cls = CLS_ALU;
    else if (opc == OP_BEQ)      cls = CLS_BEQ;
    else if (opc == OP_BNE)      cls = CLS_BNE;
    else if (opc == OP_JMP)      cls = CLS_JMP;
    else                         cls = CLS_ILLEGAL;
    return cls;
  endfunction

  // Address generation adds, branch compare subtracts, all else is
  // decoded by the ALU control unit from the opcode itself.
  function automatic logic [1:0] alu_op_for(input logic [3:0] opc);
    logic [1:0] op;
    if (opc == OP_LW || opc == OP_SW)        op = ALU_OP_ADD;
    else if (opc == OP_BEQ || opc == OP_BNE) op = ALU_OP_SUB;
    else                                     op = ALU_OP_FUNC;
    return op;
  endfunction

endpackage : qx1_exec_ctrl_pkg
`default_nettype wire

// File: rtl/qx1_exec_ctrl_mem_timer.sv
`default_nettype none
// ============================================================================
// Module      : qx1_mem_timer
// Description : Memory-wait watchdog. Counts cycles while enabled, clears
//               on request, flags expiry in the cycle whose increment would
//               reach MEM_TIMEOUT. MEM_TIMEOUT = 0 disables expiry.
// Revision    : 1.0 - initial release
// ============================================================================
module qx1_mem_timer #(
  parameter int MEM_TIMEOUT = 15,
  parameter int TMR_W       = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  logic [TMR_W-1:0] count;

  // Wait counter: clear has priority over counting
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (count_en) begin
      count <= count + 1'b1;
    end
  end

  generate
    if (MEM_TIMEOUT == 0) begin : g_no_timeout
      assign expired = 1'b0;
    end else begin : g_timeout
      // Count holds the number of already-elapsed waiting cycles, so the
      // limit is hit in the cycle where count equals MEM_TIMEOUT-1.
      localparam logic [TMR_W-1:0] LIMIT = TMR_W'(MEM_TIMEOUT - 1);
      assign expired = (count == LIMIT);
    end
  endgenerate

endmodule : qx1_mem_timer
`default_nettype wire

// File: rtl/qx1_exec_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : qx1_exec_ctrl
// Description : QX1 multi-cycle execute sequencer. Accepts one instruction
//               over valid/ready, decodes it and sequences register reads,
//               ALU control, data-memory access, writeback and PC update.
// Revision    : 1.0 - initial release
// ============================================================================
module qx1_exec_ctrl
  import qx1_exec_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int TMR_W       = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [15:0] instr,
  output logic [1:0]  alu_op,
  output logic [3:0]  alu_opcode,
  input  logic        alu_zero,
  output logic        rf_rd_en,
  output logic [2:0]  rf_rs1,
  output logic [2:0]  rf_rs2,
  output logic        rf_we,
  output logic [2:0]  rf_wa,
  output logic        wb_sel,
  output logic        mem_req,
  output logic        mem_we,
  input  logic        mem_ack,
  output logic        pc_inc,
  output logic        pc_load,
  output logic        illegal_op,
  output logic        bus_err,
  output logic        busy
);

  logic [2:0]  state;
  logic [2:0]  next_state;
  logic [15:3] instr_reg;
  logic [1:0]  alu_op_reg;
  logic [3:0]  alu_opcode_reg;
  op_class_e   cls;
  logic        accept;
  logic        timer_clear;
  logic        timer_count;
  logic        timer_expired;
  logic        unused_instr_bits;

  // Low three instruction bits carry no field this block consumes
  assign unused_instr_bits = ^instr[2:0];

  // Ready is held low while reset is asserted so every output reads 0
  assign instr_ready = (state == ST_IDLE) && rst_n;
  assign busy        = (state != ST_IDLE);
  assign accept      = instr_valid && instr_ready;

  assign cls        = classify(instr_reg[OPC_HI:OPC_LO]);
  assign alu_op     = alu_op_reg;
  assign alu_opcode = alu_opcode_reg;

  assign timer_clear = (state != ST_MEM);
  assign timer_count = (state == ST_MEM) && !mem_ack;

  qx1_mem_timer #(
    .MEM_TIMEOUT (MEM_TIMEOUT),
    .TMR_W       (TMR_W)
  ) u_mem_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (timer_clear),
    .count_en (timer_count),
    .expired  (timer_expired)
  );

  // Next-state and per-state strobes; strobes are decoded from state so a
  // reset assertion silences them without waiting for a clock edge.
  always_comb begin
    next_state = state;
    rf_rd_en   = 1'b0;
    rf_rs1     = 3'd0;
    rf_rs2     = 3'd0;
    rf_we      = 1'b0;
    rf_wa      = 3'd0;
    wb_sel     = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    pc_inc     = 1'b0;
    pc_load    = 1'b0;
    illegal_op = 1'b0;
    bus_err    = 1'b0;

    case (state)
      ST_IDLE: begin
        if (accept) begin
          next_state = ST_DECODE;
        end
      end

      ST_DECODE: begin
        rf_rd_en = 1'b1;
        rf_rs1   = instr_reg[RS1_HI:RS1_LO];
        rf_rs2   = instr_reg[RS2_HI:RS2_LO];
        if (cls == CLS_ILLEGAL) begin
          // Undefined opcodes are skipped: flag and step past them
          illegal_op = 1'b1;
          pc_inc     = 1'b1;
          next_state = ST_IDLE;
        end else begin
          next_state = ST_EXEC;
        end
      end

      ST_EXEC: begin
        case (cls)
          CLS_ALU:   next_state = ST_WB;
          CLS_LOAD:  next_state = ST_MEM;
          CLS_STORE: next_state = ST_MEM;
          CLS_BEQ: begin
            pc_load    = alu_zero;
            pc_inc     = !alu_zero;
            next_state = ST_IDLE;
          end
          CLS_BNE: begin
            pc_load    = !alu_zero;
            pc_inc     = alu_zero;
            next_state = ST_IDLE;
          end
          CLS_JMP: begin
            pc_load    = 1'b1;
            next_state = ST_IDLE;
          end
          default: next_state = ST_IDLE;
        endcase
      end

      ST_MEM: begin
        mem_req = 1'b1;
        mem_we  = (cls == CLS_STORE);
        // An ack arriving in the limit cycle still completes the access
        if (mem_ack) begin
          if (cls == CLS_LOAD) begin
            next_state = ST_WB;
          end else begin
            pc_inc     = 1'b1;
            next_state = ST_IDLE;
          end
        end else if (timer_expired) begin
          bus_err    = 1'b1;
          next_state = ST_IDLE;
        end
      end

      ST_WB: begin
        rf_we      = 1'b1;
        rf_wa      = instr_reg[RD_HI:RD_LO];
        wb_sel     = (cls == CLS_LOAD);
        pc_inc     = 1'b1;
        next_state = ST_IDLE;
      end

      default: next_state = ST_IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Instruction latch, loaded on the accept handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_reg <= '0;
    end else if (accept) begin
      instr_reg <= instr[15:3];
    end
  end

  // ALU control registers: loaded at accept so they are already valid in
  // DECODE, held for the whole instruction, cleared on return to IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_op_reg     <= ALU_OP_FUNC;
      alu_opcode_reg <= 4'd0;
    end else if (accept) begin
      alu_op_reg     <= alu_op_for(instr[OPC_HI:OPC_LO]);
      alu_opcode_reg <= instr[OPC_HI:OPC_LO];
    end else if ((state != ST_IDLE) && (next_state == ST_IDLE)) begin
      alu_op_reg     <= ALU_OP_FUNC;
      alu_opcode_reg <= 4'd0;
    end
  end

endmodule : qx1_exec_ctrl
`default_nettype wire
